// File: rtl/ram_bist_pkg.sv
// Shared state encoding and phase helpers for the RAM march tester.
package ram_bist_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    W0   = 3'd1,
    R0   = 3'd2,
    W1   = 3'd3,
    R1   = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_DONE = 3'd5;

  function automatic logic phase_active(input state_t s);
    return (s == W0) || (s == R0) || (s == W1) || (s == R1);
  endfunction

  // W0/R0 walk addresses upward, W1/R1 walk downward
  function automatic logic phase_up(input state_t s);
    return (s == W0) || (s == R0);
  endfunction

  // Phases that use the inverted background ~P
  function automatic logic phase_inv(input state_t s);
    return (s == W1) || (s == R1);
  endfunction

  function automatic logic phase_wr(input state_t s);
    return (s == W0) || (s == W1);
  endfunction

  function automatic logic phase_rd(input state_t s);
    return (s == R0) || (s == R1);
  endfunction

endpackage

// File: rtl/ram_bist_addr_gen.sv
// Up/down address counter with synchronous load and end-of-phase flag.
module ram_bist_addr_gen #(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              en,
  input  logic              up,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  assign last = up ? (addr == '1) : (addr == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    addr <= '0;
    else if (load) addr <= load_val;
    else if (en)   addr <= up ? addr + 1'b1 : addr - 1'b1;
  end

endmodule

// File: rtl/ram_bist_ctrl.sv
// March tester for a small synchronous-write RAM port: W0/R0 with P, W1/R1 with ~P.
// Optional BIST_STOP_ON_FAIL_EN ends the march at the first mismatch.
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int               DATA_W  = 8,
  parameter int               ADDR_W  = 3,
  parameter logic [DATA_W-1:0] PATTERN = 8'h55
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [ADDR_W+1:0] err_count,
  output logic              ram_wr,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_add,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  localparam int CNT_W = ADDR_W + 2;

  state_t              state, state_n;
  logic                load, cnt_en, last, mismatch, restart;
  logic [ADDR_W-1:0]   load_val, fail_n;
  logic [CNT_W-1:0]    err_n;
  logic [DATA_W-1:0]   exp_word;

  // RAM read is combinational, so compare against the word addressed this cycle
  assign exp_word = phase_inv(state) ? ~PATTERN : PATTERN;
  assign mismatch = ram_rd && (ram_data_out != exp_word);
  assign restart  = ((state == IDLE) || (state == DONE)) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: if (start) state_n = W0;
      W0:         if (last)  state_n = R0;
      R0:         if (last)  state_n = W1;
      W1:         if (last)  state_n = R1;
      R1:         if (last)  state_n = DONE;
      default:               state_n = IDLE;
    endcase
`ifdef BIST_STOP_ON_FAIL_EN
    if (mismatch) state_n = DONE;
`endif
  end

  // Counter reloads on every state change with the start address of the new phase
  always_comb begin
    load     = (state_n != state);
    load_val = (phase_active(state_n) && !phase_up(state_n)) ? '1 : '0;
    cnt_en   = phase_active(state) && !load;
  end

  ram_bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .en       (cnt_en),
    .up       (phase_up(state)),
    .addr     (ram_add),
    .last     (last)
  );

  always_comb begin
    err_n  = err_count;
    fail_n = fail_addr;
    if (restart) begin
      err_n  = '0;
      fail_n = '0;
    end else if (mismatch) begin
      if (err_count == '0) fail_n = ram_add;
      if (!(&err_count))   err_n  = err_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_addr   <= '0;
      err_count   <= '0;
      ram_wr      <= 1'b0;
      ram_rd      <= 1'b0;
      ram_data_in <= '0;
    end else begin
      busy        <= phase_active(state_n);
      done        <= (state_n == DONE);
      pass        <= (state_n == DONE) && (err_n == '0);
      fail_addr   <= fail_n;
      err_count   <= err_n;
      ram_wr      <= phase_wr(state_n);
      ram_rd      <= phase_rd(state_n);
      ram_data_in <= (state_n == W0) ? PATTERN :
                     (state_n == W1) ? ~PATTERN : '0;
    end
  end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Directed bench for ram_bist_ctrl with an 8x8 RAM model and injectable read faults.
module tb_ram_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, pass;
  logic [2:0] fail_addr;
  logic [4:0] err_count;
  logic       ram_wr, ram_rd;
  logic [2:0] ram_add;
  logic [7:0] ram_data_in, ram_data_out;

  int n_assert = 0;
  int n_fail   = 0;
  int fault    = 0;   // 0 none, 1 addr 5 bit0 stuck-1, 2 data bus stuck-0

  logic [7:0] mem [8];

  always #5 clk = ~clk;

  ram_bist_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .fail_addr    (fail_addr),
    .err_count    (err_count),
    .ram_wr       (ram_wr),
    .ram_rd       (ram_rd),
    .ram_add      (ram_add),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );

  always @(posedge clk) if (ram_wr) mem[ram_add] <= ram_data_in;

  always_comb begin
    ram_data_out = mem[ram_add];
    if (fault == 1 && ram_add == 3'd5) ram_data_out = mem[ram_add] | 8'h01;
    else if (fault == 2)               ram_data_out = 8'h00;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_fail_addr"}, fail_addr, 0);
    check({tag, "_err"}, err_count, 0);
    check({tag, "_wr"}, ram_wr, 0);
    check({tag, "_rd"}, ram_rd, 0);
    check({tag, "_add"}, ram_add, 0);
    check({tag, "_din"}, ram_data_in, 0);
  endtask

  // Called one cycle after start is sampled; walks all 32 march cycles then checks done
  task automatic run_march(input string tag);
    int ph, j;
    for (int i = 0; i < 32; i++) begin
      ph = i / 8;
      j  = i % 8;
      check({tag, "_add"}, ram_add, (ph < 2) ? j : 7 - j);
      check({tag, "_wr"}, ram_wr, (ph % 2) == 0);
      check({tag, "_rd"}, ram_rd, (ph % 2) == 1);
      if (ph == 0) check({tag, "_din"}, ram_data_in, 8'h55);
      if (ph == 2) check({tag, "_din"}, ram_data_in, 8'hAA);
      check({tag, "_busy"}, busy, 1);
      check({tag, "_done_early"}, done, 0);
      tick();
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_end"}, busy, 0);
  endtask

  // Port-protocol monitor
  always @(negedge clk) begin
    if (rst_n) begin
      check("wr_rd_excl", ram_wr && ram_rd, 0);
      if (!busy) begin
        check("idle_wr", ram_wr, 0);
        check("idle_rd", ram_rd, 0);
      end
    end
  end

  initial begin
    // 1: reset values, then a clean march
    ticks(3);
    check_reset_vals("rst");
    rst_n = 1'b1;
    tick();
    check("idle_hold_done", done, 0);
    pulse_start();
    run_march("t1");
    check("t1_pass", pass, 1);
    check("t1_err", err_count, 0);
    check("t1_fail_addr", fail_addr, 0);
    tick();
    check("t1_done_hold", done, 1);

    // 2: addr 5 bit0 stuck-1; P=55 has bit0=1 so only the R1 read (AA) at addr 5 fails
    fault = 1;
    pulse_start();
    ticks(16);
    check("t2_err_after_r0", err_count, 0);
    check("t2_pass_cleared", pass, 0);
    ticks(16);
    check("t2_done", done, 1);
    check("t2_pass", pass, 0);
    check("t2_fail_addr", fail_addr, 5);
    check("t2_err", err_count, 1);

    // 3: read data bus stuck at zero
    fault = 2;
    pulse_start();
`ifdef BIST_STOP_ON_FAIL_EN
    ticks(8);
    check("t3_done_before", done, 0);
    tick();
    check("t3_done", done, 1);
    check("t3_err", err_count, 1);
    check("t3_fail_addr", fail_addr, 0);
    check("t3_pass", pass, 0);
    check("t3_rd", ram_rd, 0);
`else
    ticks(32);
    check("t3_done", done, 1);
    check("t3_err", err_count, 16);
    check("t3_fail_addr", fail_addr, 0);
    check("t3_pass", pass, 0);
`endif

    // 4: asynchronous reset in the middle of R0
    fault = 0;
    pulse_start();
    ticks(11);
    check("t4_busy", busy, 1);
    check("t4_rd", ram_rd, 1);
    check("t4_add", ram_add, 3);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("t4_async");
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    run_march("t4_rerun");
    check("t4_pass", pass, 1);
    check("t4_err", err_count, 0);

    // 5: start held 40 cycles; first run has a fault, restart from DONE clears results
    fault = 1;
    start = 1'b1;
    tick();
    ticks(19);
    check("t5_busy", busy, 1);
    check("t5_add", ram_add, 4);
    check("t5_wr", ram_wr, 1);
    ticks(13);
    check("t5_done1", done, 1);
    check("t5_pass1", pass, 0);
    check("t5_err1", err_count, 1);
    check("t5_fail1", fail_addr, 5);
    fault = 0;
    tick();
    check("t5_restart_busy", busy, 1);
    check("t5_restart_done", done, 0);
    check("t5_restart_pass", pass, 0);
    check("t5_restart_err", err_count, 0);
    check("t5_restart_fail", fail_addr, 0);
    check("t5_restart_add", ram_add, 0);
    check("t5_restart_wr", ram_wr, 1);
    ticks(6);
    start = 1'b0;
    check("t5_busy_mid", busy, 1);
    ticks(25);
    check("t5_done2_early", done, 0);
    tick();
    check("t5_done2", done, 1);
    check("t5_pass2", pass, 1);
    check("t5_err2", err_count, 0);
    ticks(2);
    check("t5_no_third", done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
